// File: rtl/id_ex_pipe_stage_if.sv
// ID/EX stage bus: decode-side request fields with valid/ready, execute-side
// registered fields with valid/ready, plus the pipeline flush strobe.
//   master : the environment around the stage (drives ID inputs, EX ready, flush)
//   slave  : the pipeline stage itself
interface id_ex_pipe_stage_if #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 8
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] ctrl_in;
   logic [XLEN-1:0]   rs1_data_in;
   logic [XLEN-1:0]   rs2_data_in;
   logic [REG_AW-1:0] rs1_in;
   logic [REG_AW-1:0] rs2_in;
   logic [REG_AW-1:0] rd_in;
   logic [XLEN-1:0]   imm_in;
   logic [XLEN-1:0]   pc_in;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] ctrl_out;
   logic [XLEN-1:0]   rs1_data_out;
   logic [XLEN-1:0]   rs2_data_out;
   logic [REG_AW-1:0] rs1_out;
   logic [REG_AW-1:0] rs2_out;
   logic [REG_AW-1:0] rd_out;
   logic [XLEN-1:0]   imm_out;
   logic [XLEN-1:0]   pc_out;

   modport master (
      output flush, in_valid, ctrl_in, rs1_data_in, rs2_data_in, rs1_in, rs2_in,
             rd_in, imm_in, pc_in, out_ready,
      input  in_ready, out_valid, ctrl_out, rs1_data_out, rs2_data_out, rs1_out,
             rs2_out, rd_out, imm_out, pc_out
   );

   modport slave (
      input  flush, in_valid, ctrl_in, rs1_data_in, rs2_data_in, rs1_in, rs2_in,
             rd_in, imm_in, pc_in, out_ready,
      output in_ready, out_valid, ctrl_out, rs1_data_out, rs2_data_out, rs1_out,
             rs2_out, rd_out, imm_out, pc_out
   );
endinterface

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and optional skid.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - id_ex_pipe_stage_if.slave: flush, ID-side valid/ready + fields,
//          EX-side valid/ready + registered fields
// SKID=1: two-entry (main + skid) buffer, in_ready comes straight from a flop.
// SKID=0: single entry, in_ready = !out_valid || out_ready (combinational).
// The interface instance must be built with the same XLEN/REG_AW/CTRL_W.
module id_ex_pipe_stage #(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1
) (
   input logic              clk,
   input logic              rst,
   id_ex_pipe_stage_if.slave bus
);
   localparam int PW = CTRL_W + 4*XLEN + 3*REG_AW;

   logic [PW-1:0]     in_pl;
   logic [PW-1:0]     main_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              out_valid;
   logic              in_ready;
   logic              in_xfer;
   logic              out_xfer;

   assign in_pl = {bus.ctrl_in, bus.rs1_data_in, bus.rs2_data_in, bus.rs1_in,
                   bus.rs2_in, bus.rd_in, bus.imm_in, bus.pc_in};

   assign in_xfer  = bus.in_valid && in_ready;
   assign out_xfer = out_valid && bus.out_ready;

   assign {ctrl_q, bus.rs1_data_out, bus.rs2_data_out, bus.rs1_out,
           bus.rs2_out, bus.rd_out, bus.imm_out, bus.pc_out} = main_q;

   // A bubble must never carry write/memory/branch enables downstream.
   assign bus.ctrl_out  = out_valid ? ctrl_q : '0;
   assign bus.out_valid = out_valid;
   assign bus.in_ready  = in_ready;

   generate
      if (SKID != 0) begin : g_skid
         localparam logic [1:0] S_EMPTY = 2'd0;
         localparam logic [1:0] S_ONE   = 2'd1;
         localparam logic [1:0] S_TWO   = 2'd2;

         logic [1:0]    state_q, state_d;
         logic [PW-1:0] skid_q;
         logic          in_ready_q;
         logic          load_main, load_skid, main_from_skid;

         always_comb begin
            state_d        = state_q;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
            case (state_q)
               S_EMPTY: if (in_xfer) begin
                  load_main = 1'b1;
                  state_d   = S_ONE;
               end
               S_ONE: begin
                  if (in_xfer && out_xfer) begin
                     load_main = 1'b1;
                  end else if (in_xfer) begin
                     // main still owned by EX; park the newer entry behind it
                     load_skid = 1'b1;
                     state_d   = S_TWO;
                  end else if (out_xfer) begin
                     state_d = S_EMPTY;
                  end
               end
               S_TWO: if (out_xfer) begin
                  main_from_skid = 1'b1;
                  state_d        = S_ONE;
               end
               default: state_d = S_EMPTY;
            endcase
            if (bus.flush) begin
               state_d        = S_EMPTY;
               load_main      = 1'b0;
               load_skid      = 1'b0;
               main_from_skid = 1'b0;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state_q    <= S_EMPTY;
               main_q     <= '0;
               skid_q     <= '0;
               in_ready_q <= 1'b1;
            end else begin
               state_q    <= state_d;
               // registered ready: precomputed from the next state
               in_ready_q <= (state_d != S_TWO);
               if (load_main)           main_q <= in_pl;
               else if (main_from_skid) main_q <= skid_q;
               if (load_skid)           skid_q <= in_pl;
            end
         end

         assign out_valid = (state_q != S_EMPTY);
         assign in_ready  = in_ready_q;
      end else begin : g_noskid
         logic vld_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_q  <= 1'b0;
               main_q <= '0;
            end else if (bus.flush) begin
               vld_q <= 1'b0;
            end else if (in_xfer) begin
               vld_q  <= 1'b1;
               main_q <= in_pl;
            end else if (out_xfer) begin
               vld_q <= 1'b0;
            end
         end

         assign out_valid = vld_q;
         assign in_ready  = !vld_q || bus.out_ready;
      end
   endgenerate
endmodule
